mem_stage_lsu: RTL and testbench

Parametrised next-generation MEM stage with MEM/WB pipeline register. It replaces the fixed word-only, single-cycle data memory access with three additions:
- byte, half and word loads/stores using RISC-V funct3 encodings, with sign/zero extension;
- an external variable-latency memory port using a req/ack handshake, which stalls the pipeline while a request is outstanding;
- misalignment detection.

It sits between the EX/MEM register and writeback.

---
 rtl/riscv_pipe_pkg.sv | 36 +++
 rtl/mem_stage_lsu_if.sv | 23 ++
 rtl/lsu_load_align.sv | 31 +++
 rtl/mem_stage_lsu.sv | 124 ++++++++++++
 tb/tb_mem_stage_lsu.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared constants, FSM state type and width helpers for the MEM-stage load/store unit.
package riscv_pipe_pkg;

    // Access size, encoded in funct3[1:0]; funct3[2] selects zero-extension.
    localparam logic [1:0] SizeB = 2'd0;
    localparam logic [1:0] SizeH = 2'd1;
    localparam logic [1:0] SizeW = 2'd2;
    localparam logic [1:0] SizeD = 2'd3;

    typedef enum logic [0:0] {
        StIdle,
        StWait
    } lsu_state_e;

    function automatic int unsigned bytes_per_word(input int unsigned xlen);
        return xlen / 8;
    endfunction

    function automatic int unsigned off_bits(input int unsigned xlen);
        return $clog2(xlen / 8);
    endfunction

    // Bytes touched by an access, clamped to the datapath width.
    function automatic int unsigned access_bytes(input logic [2:0] funct3, input int unsigned nb);
        int unsigned s;
        unique case (funct3[1:0])
            SizeB:   s = 1;
            SizeH:   s = 2;
            SizeW:   s = 4;
            SizeD:   s = 8;
            default: s = 1;
        endcase
        return (s > nb) ? nb : s;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Variable-latency data memory port: req/ack handshake, byte enables, full-width data.
interface mem_stage_lsu_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
);
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [XLEN/8-1:0]   mem_be;
    logic [XLEN-1:0]     mem_wdata;
    logic                mem_ack;
    logic [XLEN-1:0]     mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Load data alignment: shifts the addressed lane down, truncates to the access size and extends.
module lsu_load_align
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OffW = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic [OffW-1:0] off_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] read_data_o
);
    localparam int unsigned NumBytes = bytes_per_word(XLEN);

    logic [XLEN-1:0] shifted;
    logic            sign;
    int unsigned     sz;

    always_comb begin
        sz      = access_bytes(funct3_i, NumBytes);
        shifted = mem_rdata_i >> {off_i, 3'b000};
        sign    = 1'b0;
        for (int unsigned b = 0; b < NumBytes; b++) begin
            if (b == sz - 1) sign = ~funct3_i[2] & shifted[8*b+7];
        end
        for (int unsigned b = 0; b < NumBytes; b++) begin
            read_data_o[8*b +: 8] = (b < sz) ? shifted[8*b +: 8] : {8{sign}};
        end
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage with MEM/WB register: sized loads/stores over a req/ack memory port with stalling.
// Optional MISALIGN_TRAP_EN: misaligned accesses skip the bus and retire with MisalignW set.
module mem_stage_lsu
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned RES_SRC_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ValidM,
    input  logic                  RegWriteM,
    input  logic                  MemWriteM,
    input  logic                  MemReadM,
    input  logic [2:0]            Funct3M,
    input  logic [RES_SRC_W-1:0]  ResultSrcM,
    input  logic [REG_ADDR_W-1:0] RD_M,
    input  logic [XLEN-1:0]       PCPlus4M,
    input  logic [XLEN-1:0]       ALU_ResultM,
    input  logic [XLEN-1:0]       WriteDataM,
    output logic                  StallM,
    mem_stage_lsu_if.master       bus,
    output logic                  ValidW,
    output logic                  RegWriteW,
    output logic [RES_SRC_W-1:0]  ResultSrcW,
    output logic [REG_ADDR_W-1:0] RD_W,
    output logic [XLEN-1:0]       PCPlus4W,
    output logic [XLEN-1:0]       ALU_ResultW,
    output logic [XLEN-1:0]       ReadDataW,
    output logic                  MisalignW
);
    localparam int unsigned NumBytes = bytes_per_word(XLEN);
    localparam int unsigned OffW     = off_bits(XLEN);

    lsu_state_e            state_q;
    logic                  valid_w_q, reg_write_w_q, misalign_w_q;
    logic [RES_SRC_W-1:0]  result_src_w_q;
    logic [REG_ADDR_W-1:0] rd_w_q;
    logic [XLEN-1:0]       pc_plus4_w_q, alu_result_w_q, read_data_w_q;

    logic            access, misaligned, trap, req;
    logic [OffW-1:0] raw_off, off;
    logic [XLEN-1:0] load_data;
    int unsigned     sz;

    always_comb begin
        access     = ValidM & (MemReadM | MemWriteM);
        sz         = access_bytes(Funct3M, NumBytes);
        raw_off    = ALU_ResultM[OffW-1:0];
        misaligned = (32'(raw_off) & (sz - 1)) != 0;
`ifdef MISALIGN_TRAP_EN
        trap = access & misaligned;
        off  = raw_off;
`else
        // Unchecked misalignment falls back to the aligned-down word.
        trap = 1'b0;
        off  = misaligned ? '0 : raw_off;
`endif
        req    = ~rst & ((state_q == StWait) | (access & ~trap));
        StallM = req & ~bus.mem_ack;
    end

    always_comb begin
        bus.mem_req  = req;
        bus.mem_we   = req & MemWriteM;
        bus.mem_addr = ADDR_W'(ALU_ResultM) & ~ADDR_W'(NumBytes - 1);
        for (int unsigned b = 0; b < NumBytes; b++) begin
            bus.mem_be[b]          = (b >= 32'(off)) && (b < 32'(off) + sz);
            bus.mem_wdata[8*b +: 8] = WriteDataM[8*(b % sz) +: 8];
        end
    end

    lsu_load_align #(
        .XLEN (XLEN),
        .OffW (OffW)
    ) u_load_align (
        .mem_rdata_i (bus.mem_rdata),
        .off_i       (off),
        .funct3_i    (Funct3M),
        .read_data_o (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            valid_w_q      <= 1'b0;
            reg_write_w_q  <= 1'b0;
            misalign_w_q   <= 1'b0;
            result_src_w_q <= '0;
            rd_w_q         <= '0;
            pc_plus4_w_q   <= '0;
            alu_result_w_q <= '0;
            read_data_w_q  <= '0;
        end else if (req && !bus.mem_ack) begin
            // Request outstanding: bubble into W, other fields hold.
            state_q       <= StWait;
            valid_w_q     <= 1'b0;
            reg_write_w_q <= 1'b0;
            misalign_w_q  <= 1'b0;
        end else begin
            state_q        <= StIdle;
            valid_w_q      <= ValidM;
            reg_write_w_q  <= RegWriteM & ~trap;
            misalign_w_q   <= trap;
            result_src_w_q <= ResultSrcM;
            rd_w_q         <= RD_M;
            pc_plus4_w_q   <= PCPlus4M;
            alu_result_w_q <= ALU_ResultM;
            read_data_w_q  <= (req && !MemWriteM) ? load_data : '0;
        end
    end

    assign ValidW      = valid_w_q;
    assign RegWriteW   = reg_write_w_q;
    assign MisalignW   = misalign_w_q;
    assign ResultSrcW  = result_src_w_q;
    assign RD_W        = rd_w_q;
    assign PCPlus4W    = pc_plus4_w_q;
    assign ALU_ResultW = alu_result_w_q;
    assign ReadDataW   = read_data_w_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed cases then random accesses against an arithmetic model.
module tb_mem_stage_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        ValidM, RegWriteM, MemWriteM, MemReadM;
    logic [2:0]  Funct3M;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, ALU_ResultM, WriteDataM;
    logic        StallM;
    logic        ValidW, RegWriteW, MisalignW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

    int total = 0;
    int bad   = 0;

    mem_stage_lsu_if #(.XLEN(32), .ADDR_W(32)) bus ();

    mem_stage_lsu #(
        .XLEN       (32),
        .ADDR_W     (32),
        .REG_ADDR_W (5),
        .RES_SRC_W  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ValidM      (ValidM),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .MemReadM    (MemReadM),
        .Funct3M     (Funct3M),
        .ResultSrcM  (ResultSrcM),
        .RD_M        (RD_M),
        .PCPlus4M    (PCPlus4M),
        .ALU_ResultM (ALU_ResultM),
        .WriteDataM  (WriteDataM),
        .StallM      (StallM),
        .bus         (bus),
        .ValidW      (ValidW),
        .RegWriteW   (RegWriteW),
        .ResultSrcW  (ResultSrcW),
        .RD_W        (RD_W),
        .PCPlus4W    (PCPlus4W),
        .ALU_ResultW (ALU_ResultW),
        .ReadDataW   (ReadDataW),
        .MisalignW   (MisalignW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string what, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s: got %0h expected %0h", tag, what, obs, exp);
        end
    endtask

    // One M-stage instruction; ack arrives dly cycles after the request is first seen.
    task automatic run_op(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdat, input int dly, input string tag);
        int unsigned s, off;
        logic        acc, mis, trap, regw;
        logic [31:0] mask, e_ld, e_wd, pc;
        logic [3:0]  e_be;
        logic [4:0]  rdr;
        logic [1:0]  rs;

        rdr  = 5'($urandom);
        pc   = $urandom;
        rs   = 2'($urandom);
        acc  = v & (rd | wr);
        regw = v & (acc ? (rd & ~wr) : 1'($urandom));

        ValidM = v; MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALU_ResultM = addr;
        WriteDataM = wd; RD_M = rdr; PCPlus4M = pc; ResultSrcM = rs; RegWriteM = regw;
        bus.mem_rdata = rdat; bus.mem_ack = 1'b0;

        s    = 1 << f3[1:0];
        off  = addr % 4;
        mis  = (off % s) != 0;
`ifdef MISALIGN_TRAP_EN
        trap = acc & mis;
`else
        trap = 1'b0;
        if (mis) off = 0;
`endif
        mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 1);
        e_be = 4'(((1 << s) - 1) << off);
        e_wd = (wd & mask) * (32'hFFFF_FFFF / mask);
        e_ld = (rdat >> (8 * off)) & mask;
        if (!f3[2] && e_ld[8*s-1]) e_ld = e_ld | ~mask;

        if (acc && !trap) begin
            for (int k = 0; k <= dly; k++) begin
                bus.mem_ack = (k == dly);
                #4;
                chk(tag, "mem_req", bus.mem_req, 1);
                chk(tag, "StallM", StallM, k < dly);
                if (k == 0) begin
                    chk(tag, "mem_addr", bus.mem_addr, addr & ~32'd3);
                    chk(tag, "mem_we", bus.mem_we, wr);
                    chk(tag, "mem_be", bus.mem_be, e_be);
                    if (wr) chk(tag, "mem_wdata", bus.mem_wdata, e_wd);
                end
                @(posedge clk); #1;
                if (k < dly) begin
                    chk(tag, "bubble_ValidW", ValidW, 0);
                    chk(tag, "bubble_RegWriteW", RegWriteW, 0);
                end
            end
            bus.mem_ack = 1'b0;
            chk(tag, "ValidW", ValidW, 1);
            chk(tag, "RegWriteW", RegWriteW, regw);
            chk(tag, "MisalignW", MisalignW, 0);
            chk(tag, "ReadDataW", ReadDataW, wr ? 32'd0 : e_ld);
        end else begin
            bus.mem_ack = 1'($urandom);
            #4;
            chk(tag, "no_req", bus.mem_req, 0);
            chk(tag, "no_stall", StallM, 0);
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
            chk(tag, "ValidW", ValidW, v);
            chk(tag, "RegWriteW", RegWriteW, trap ? 1'b0 : regw);
            chk(tag, "MisalignW", MisalignW, trap);
        end
        chk(tag, "RD_W", RD_W, rdr);
        chk(tag, "PCPlus4W", PCPlus4W, pc);
        chk(tag, "ResultSrcW", ResultSrcW, rs);
        chk(tag, "ALU_ResultW", ALU_ResultW, addr);
    endtask

    initial begin
        logic [2:0] f3_tab [5];
        f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
        f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;

        rst = 1'b1;
        ValidM = 0; RegWriteM = 0; MemWriteM = 0; MemReadM = 0; Funct3M = 0; ResultSrcM = 0;
        RD_M = 0; PCPlus4M = 0; ALU_ResultM = 0; WriteDataM = 0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset", "ValidW", ValidW, 0);
        chk("reset", "RegWriteW", RegWriteW, 0);
        chk("reset", "ReadDataW", ReadDataW, 0);
        chk("reset", "ALU_ResultW", ALU_ResultW, 0);
        chk("reset", "mem_req", bus.mem_req, 0);
        chk("reset", "StallM", StallM, 0);
        rst = 1'b0;

        run_op(1, 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, "lw");
        run_op(1, 1, 0, 3'b000, 32'h103, 32'h0, 32'h8011_2233, 0, "lb");
        run_op(1, 1, 0, 3'b100, 32'h103, 32'h0, 32'h8011_2233, 0, "lbu");
        run_op(1, 1, 0, 3'b101, 32'h102, 32'h0, 32'h8011_2233, 0, "lhu");
        run_op(1, 0, 1, 3'b000, 32'h201, 32'h0000_00AB, $urandom, 0, "sb");
        run_op(1, 0, 1, 3'b001, 32'h202, 32'h1234_5678, $urandom, 0, "sh");
        run_op(1, 1, 0, 3'b010, 32'h300, 32'h0, 32'hCAFE_F00D, 3, "lw_wait3");
        run_op(0, 0, 0, 3'b010, 32'h55, 32'h0, 32'h0, 0, "alu_nop");

        // Reset lands while a load is waiting; a late ack must be ignored.
        ValidM = 1; MemReadM = 1; MemWriteM = 0; RegWriteM = 1; Funct3M = 3'b010;
        ALU_ResultM = 32'h400; bus.mem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #4;
        chk("rst_wait", "req_in_reset", bus.mem_req, 0);
        @(posedge clk); #1;
        rst = 1'b0; ValidM = 0; MemReadM = 0; RegWriteM = 0;
        chk("rst_wait", "ValidW", ValidW, 0);
        chk("rst_wait", "ALU_ResultW", ALU_ResultW, 0);
        chk("rst_wait", "PCPlus4W", PCPlus4W, 0);
        chk("rst_wait", "RD_W", RD_W, 0);
        chk("rst_wait", "MisalignW", MisalignW, 0);
        bus.mem_ack = 1'b1;
        #4;
        chk("rst_wait", "req_after", bus.mem_req, 0);
        chk("rst_wait", "stall_after", StallM, 0);
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        chk("rst_wait", "ValidW_after_ack", ValidW, 0);
        chk("rst_wait", "RegWriteW_after_ack", RegWriteW, 0);

        run_op(1, 1, 0, 3'b010, 32'h102, 32'h0, 32'h0BAD_C0DE, 1, "lw_misaligned");

        for (int i = 0; i < 60; i++) begin
            run_op(1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
                   f3_tab[$urandom_range(0, 4)], $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
